adder16: RTL and testbench

- WIDTH-bit unsigned binary adder producing a sum and a carry-out.
- Combinational result is available with zero latency; a registered copy is available one clock later.
- Sits in datapaths needing fast unsigned addition with overflow (carry) detection.
- The combinational path is a carry-lookahead structure built from 4-bit lookahead groups, not a ripple chain.

---
 rtl/adder16.sv | 96 +++++++++
 tb/tb_adder16.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adder16.sv
// adder16: WIDTH-bit unsigned carry-lookahead adder with a registered copy.
//
// Combinational path: per-bit generate/propagate feed 4-bit lookahead groups;
// a second-level lookahead unit turns group G/P plus cin into group carry-ins,
// and each group expands its carry-in into per-bit carries locally.
//
// Registered path: out_q/carry_q capture on a rising clk edge while en=1.
// valid_q is a one-cycle flag: high for exactly the cycle following an edge
// where en=1 (no ready/backpressure; downstream must take it that cycle).
module adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic [WIDTH-1:0] out_q,
  output logic             carry_q,
  output logic             valid_q
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;   // bit generate
  logic [WIDTH-1:0] p;   // bit propagate
  logic [WIDTH-1:0] c;   // carry into each bit
  logic [NG-1:0]    gg;  // group generate
  logic [NG-1:0]    gp;  // group propagate
  logic [NG:0]      gc;  // carry into each group; gc[NG] is the final carry

  assign g = a & b;
  assign p = a ^ b;

  // First level: group G/P and per-bit carries inside each 4-bit group.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] gl;
    logic [3:0] pl;
    assign gl = g[4*k +: 4];
    assign pl = p[4*k +: 4];

    assign gg[k] = gl[3]
                 | (pl[3] & gl[2])
                 | (pl[3] & pl[2] & gl[1])
                 | (pl[3] & pl[2] & pl[1] & gl[0]);
    assign gp[k] = &pl;

    assign c[4*k]   = gc[k];
    assign c[4*k+1] = gl[0] | (pl[0] & gc[k]);
    assign c[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & gc[k]);
    assign c[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                    | (pl[2] & pl[1] & pl[0] & gc[k]);
  end

  // Second level: each group carry-in as a flat sum of products over group
  // G/P and cin, so no group waits on its neighbour's carry.
  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      logic term;
      logic acc;
      acc  = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term = gg[j];
        for (int m = j + 1; m <= k; m++) term = term & gp[m];
        acc = acc | term;
      end
      term = cin;
      for (int m = 0; m <= k; m++) term = term & gp[m];
      gc[k+1] = acc | term;
    end
  end

  assign out   = p ^ c;
  assign carry = gc[NG];

  // Capture register: load on en, hold otherwise; valid_q tracks en one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        out_q   <= out;
        carry_q <= carry;
      end
    end
  end

endmodule

// File: tb/tb_adder16.sv
// tb_adder16: directed and reference-checked vectors for adder16.
module tb_adder16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        en;
  logic [15:0] out;
  logic        carry;
  logic [15:0] out_q;
  logic        carry_q;
  logic        valid_q;

  int n_vec;
  int n_fail;

  adder16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .en      (en),
    .out     (out),
    .carry   (carry),
    .out_q   (out_q),
    .carry_q (carry_q),
    .valid_q (valid_q)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs on the falling edge, then let combinational logic settle
  task automatic apply(input logic [15:0] va, input logic [15:0] vb,
                       input logic vcin, input logic ven);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vcin;
    en  = ven;
    #1;
  endtask

  // advance past the next rising edge and sample a little later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [15:0] es, input logic ec);
    check({tag, ".out"}, {16'h0, out}, {16'h0, es});
    check({tag, ".carry"}, {31'h0, carry}, {31'h0, ec});
  endtask

  task automatic check_reg(input string tag, input logic [15:0] es, input logic ec,
                           input logic ev);
    check({tag, ".out_q"}, {16'h0, out_q}, {16'h0, es});
    check({tag, ".carry_q"}, {31'h0, carry_q}, {31'h0, ec});
    check({tag, ".valid_q"}, {31'h0, valid_q}, {31'h0, ev});
  endtask

  initial begin
    logic [16:0] ref_sum;
    n_vec  = 0;
    n_fail = 0;
    rst = 1'b1;
    a   = 16'd3;
    b   = 16'd4;
    cin = 1'b0;
    en  = 1'b1;
    #2;
    check_reg("reset", 16'h0000, 1'b0, 1'b0);
    check_comb("comb_in_reset", 16'd7, 1'b0);
    tick();
    check_reg("reset_hold", 16'h0000, 1'b0, 1'b0);

    // wrap: all-ones + 1
    @(negedge clk);
    rst = 1'b0;
    apply(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    check_comb("wrap", 16'h0000, 1'b1);
    tick();
    check_reg("wrap_reg", 16'h0000, 1'b1, 1'b1);

    apply(16'd5, 16'd23, 1'b0, 1'b1);
    check_comb("5p23", 16'd28, 1'b0);
    tick();
    check_reg("5p23_reg", 16'd28, 1'b0, 1'b1);

    apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check_comb("ones_ones_cin", 16'hFFFF, 1'b1);
    apply(16'h0000, 16'h0000, 1'b1, 1'b1);
    check_comb("zero_cin", 16'h0001, 1'b0);
    apply(16'h0000, 16'h0000, 1'b0, 1'b1);
    check_comb("zero", 16'h0000, 1'b0);
    apply(16'h0FFF, 16'h0001, 1'b0, 1'b1);
    check_comb("grp_chain", 16'h1000, 1'b0);
    apply(16'h7FFF, 16'h0000, 1'b1, 1'b1);
    check_comb("cin_chain", 16'h8000, 1'b0);
    apply(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    check_comb("alt", 16'hFFFF, 1'b0);
    apply(16'h1234, 16'hF0F0, 1'b1, 1'b1);
    check_comb("mixed", 16'h0325, 1'b1);

    // hold with en=0
    apply(16'd5, 16'd23, 1'b0, 1'b1);
    tick();
    check_reg("cap28", 16'd28, 1'b0, 1'b1);
    apply(16'd100, 16'd200, 1'b0, 1'b0);
    check_comb("300_comb", 16'd300, 1'b0);
    tick();
    check_reg("hold28", 16'd28, 1'b0, 1'b0);

    // carry_q holds too
    apply(16'h8000, 16'h8000, 1'b0, 1'b1);
    tick();
    check_reg("cap_carry", 16'h0000, 1'b1, 1'b1);
    apply(16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    check_reg("hold_carry", 16'h0000, 1'b1, 1'b0);

    // asynchronous reset between edges
    apply(16'h9000, 16'h9001, 1'b0, 1'b1);
    tick();
    check_reg("pre_rst", 16'h2001, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reg("async_rst", 16'h0000, 1'b0, 1'b0);
    check_comb("rst_comb", 16'h2001, 1'b1);
    tick();
    check_reg("rst_held", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(16'd1, 16'd2, 1'b0, 1'b1);
    tick();
    check_reg("post_rst", 16'd3, 1'b0, 1'b1);

    // reference-checked vectors
    for (int i = 0; i < 2000; i++) begin
      apply(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'b1);
      ref_sum = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      check("rand_comb", {15'h0, carry, out}, {15'h0, ref_sum});
      tick();
      check("rand_reg", {15'h0, carry_q, out_q}, {15'h0, ref_sum});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
